// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_wr_arbiter_pkg;

   typedef enum logic {ARB, BURST} arb_state_e;

   localparam int ARB_NUM_REQ   = 4;
   localparam int ARB_BURST_LEN = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin picker: first requester strictly after last_owner, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is consumed.
// Ports: req (per-producer requests), last_owner (index granted last),
//        grant_valid (some request present), grant_idx (chosen index, < NUM_REQ).
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_owner,
   output logic               grant_valid,
   output logic [IDX_W-1:0]   grant_idx
);

   // Scan from the farthest offset down to offset 1 so the closest candidate
   // after last_owner is the final assignment. The modulo keeps non-power-of-two
   // NUM_REQ from ever selecting an index past NUM_REQ-1.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (req[(int'(last_owner) + k) % NUM_REQ]) begin
            grant_valid = 1'b1;
            grant_idx   = IDX_W'((int'(last_owner) + k) % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers, bursts of up to BURST_LEN beats.
// Latency: first ack one cycle after a request is seen in ARB; one ARB bubble between grants.
// Backpressure: fifo_full stalls the owner (no ack, no write, beat count held); ownership kept until drop or burst end.
// Ports: clk, rst (sync, active-high); req/req_data from producers, ack back (one-hot beat accept);
//        fifo_full in, fifo_wr_en/fifo_data_in to the FIFO; owner_id and busy for observation.
module fifo_wr_arbiter
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = ARB_NUM_REQ,
   parameter int DATA_WIDTH = 16,
   parameter int BURST_LEN  = ARB_BURST_LEN,
   localparam int IDX_W     = $clog2(NUM_REQ),
   localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            ack,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_data_in,
   output logic [IDX_W-1:0]              owner_id,
   output logic                          busy
);

   arb_state_e       state, state_nxt;
   logic [IDX_W-1:0] owner, owner_nxt;
   logic [IDX_W-1:0] last_owner, last_owner_nxt;
   logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;

   logic             grant_valid;
   logic [IDX_W-1:0] grant_idx;
   logic             owner_req;
   logic             last_beat;
   logic             wr_fire;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req         (req),
      .last_owner  (last_owner),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // Write-side outputs. The write is also masked by rst so a burst cut by
   // reset never emits a beat in the reset cycle itself.
   always_comb begin
      owner_req    = req[owner];
      busy         = (state == BURST);
      wr_fire      = busy & owner_req & ~fifo_full & ~rst;
      fifo_wr_en   = wr_fire;
      ack          = '0;
      ack[owner]   = wr_fire;
      fifo_data_in = busy ? req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH] : '0;
      owner_id     = owner;
      last_beat    = (beat_cnt == CNT_W'(BURST_LEN - 1));
   end

   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_owner_nxt = last_owner;
      beat_cnt_nxt   = beat_cnt;
      case (state)
         ARB: begin
            if (grant_valid) begin
               owner_nxt    = grant_idx;
               beat_cnt_nxt = '0;
               state_nxt    = BURST;
            end
         end
         BURST: begin
            // A dropped request releases even if the FIFO is full.
            if (!owner_req) begin
               state_nxt      = ARB;
               last_owner_nxt = owner;
            end else if (wr_fire) begin
               beat_cnt_nxt = beat_cnt + 1'b1;
               if (last_beat) begin
                  state_nxt      = ARB;
                  last_owner_nxt = owner;
               end
            end
         end
         default: state_nxt = ARB;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ARB;
         owner      <= '0;
         last_owner <= IDX_W'(NUM_REQ - 1);
         beat_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_owner <= last_owner_nxt;
         beat_cnt   <= beat_cnt_nxt;
      end
   end

endmodule
